// File: rtl/bd_shift_sequencer.sv
// bd_shift_sequencer
//   Command-driven controller for a bidirectional shift register. It accepts one
//   command per valid/ready handshake and then drives the register's mode, serial
//   input and parallel input pins cycle by cycle. When the command finishes it
//   pulses done for one cycle.
//
//   Commands: LOAD (parallel load), SHR N (shift right), SHL N (shift left),
//             ROTR N (rotate right, fed back from sr_q[0]).
//
//   Ports
//     clk        rising-edge clock, shared with the shift register
//     rst        asynchronous active-low reset
//     cmd_valid  command present           cmd_ready  sequencer idle, can accept
//     cmd_op     00 LOAD 01 SHR 10 SHL 11 ROTR
//     cmd_count  number of shift cycles (ignored for LOAD)
//     cmd_data   parallel load value       cmd_sin    serial fill bit
//     sr_q       register contents (rotate feedback)
//     sr_mode    00 hold 01 right 10 left 11 load
//     sr_sin     register serial input     sr_d       register parallel input
//     busy       command in progress       done       one-cycle completion pulse
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a command, cmd_ready=1, register held
//   LOAD  | one cycle of parallel load with the latched data
//   SHIFT | shifting/rotating, down-counter runs until it reaches 1
//   DONE  | one-cycle completion pulse, register held

module bd_shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_sin,
   input  logic [WIDTH-1:0] sr_q,
   output logic [1:0]       sr_mode,
   output logic             sr_sin,
   output logic [WIDTH-1:0] sr_d,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   state_t             state, state_nxt;
   logic [1:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   data_q;
   logic               sin_q;
   logic               accept;

   // Only bit 0 of the register is needed, for rotate feedback.
   logic               unused_sr_q;
   assign unused_sr_q = ^sr_q[WIDTH-1:1];

   assign accept = cmd_valid && (state == ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q   <= OP_LOAD;
         cnt_q  <= '0;
         data_q <= '0;
         sin_q  <= 1'b0;
      end else if (accept) begin
         op_q   <= cmd_op;
         cnt_q  <= cmd_count;
         data_q <= cmd_data;
         sin_q  <= cmd_sin;
      end else if (state == ST_SHIFT) begin
         cnt_q  <= cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_mode   = MODE_HOLD;
      sr_sin    = 1'b0;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (accept) begin
               if (cmd_op == OP_LOAD) begin
                  state_nxt = ST_LOAD;
               end else if (cmd_count != '0) begin
                  state_nxt = ST_SHIFT;
               end else begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_LOAD: begin
            sr_mode   = MODE_LOAD;
            state_nxt = ST_DONE;
         end
         ST_SHIFT: begin
            case (op_q)
               OP_SHL: begin
                  sr_mode = MODE_LEFT;
                  sr_sin  = sin_q;
               end
               OP_ROTR: begin
                  sr_mode = MODE_RIGHT;
                  sr_sin  = sr_q[0];
               end
               default: begin
                  sr_mode = MODE_RIGHT;
                  sr_sin  = sin_q;
               end
            endcase
            if (cnt_q == CNT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Parallel input always presents the last latched data; the register only
   // looks at it in load mode.
   assign sr_d = data_q;

endmodule

// File: tb/tb_bd_shift_sequencer.sv
module tb_bd_shift_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_count = 3'd0;
   logic [3:0] cmd_data = 4'd0;
   logic       cmd_sin = 1'b0;
   logic [3:0] sr_q;
   logic [1:0] sr_mode;
   logic       sr_sin;
   logic [3:0] sr_d;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_pulses = 0;

   bd_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_count (cmd_count),
      .cmd_data  (cmd_data),
      .cmd_sin   (cmd_sin),
      .sr_q      (sr_q),
      .sr_mode   (sr_mode),
      .sr_sin    (sr_sin),
      .sr_d      (sr_d),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Behavioural model of the shift register the sequencer drives.
   logic [3:0] q_reg = 4'd0;
   assign sr_q = q_reg;
   always @(posedge clk) begin
      case (sr_mode)
         2'b01:   q_reg <= {sr_sin, q_reg[3:1]};
         2'b10:   q_reg <= {q_reg[2:0], sr_sin};
         2'b11:   q_reg <= sr_d;
         default: q_reg <= q_reg;
      endcase
   end

   always @(negedge clk) begin
      if (done === 1'b1) done_pulses++;
   end

   typedef struct {
      logic [1:0] op;
      logic [2:0] cnt;
      logic [3:0] data;
      logic       sin;
      logic [3:0] exp_q;
      int         exp_lat;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one command from an idle negedge and follows it to completion.
   task automatic run_cmd(input vec_t v, input string tag);
      int         guard;
      int         cycles;
      int         active;
      int         bad_mode;
      logic [3:0] d_seen;
      logic [1:0] em;
      em = (v.op == 2'b00) ? 2'b11 : (v.op == 2'b10) ? 2'b10 : 2'b01;
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " ready_before"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_count = v.cnt;
      cmd_data  = v.data;
      cmd_sin   = v.sin;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_count = 3'($urandom);
      cmd_data  = 4'($urandom);
      cmd_sin   = 1'($urandom);
      check({tag, " busy"}, 32'(busy), 32'd1);
      cycles = 1;
      active = 0;
      bad_mode = 0;
      d_seen = 4'hx;
      while (done !== 1'b1 && cycles < 40) begin
         if (sr_mode !== 2'b00) begin
            active++;
            if (sr_mode !== em) bad_mode++;
            if (sr_mode === 2'b11) d_seen = sr_d;
         end
         @(negedge clk);
         cycles++;
      end
      check({tag, " latency"}, 32'(cycles), 32'(v.exp_lat));
      check({tag, " q"}, 32'(sr_q), 32'(v.exp_q));
      check({tag, " active_cycles"}, 32'(active), (v.op == 2'b00) ? 32'd1 : 32'(v.cnt));
      check({tag, " mode_value"}, 32'(bad_mode), 32'd0);
      check({tag, " mode_at_done"}, 32'(sr_mode), 32'd0);
      if (v.op == 2'b00) check({tag, " sr_d"}, 32'(d_seen), 32'(v.data));
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
      check({tag, " ready_after"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      vec_t v;
      int   p;
      int   accepts;
      int   second_at;
      int   overlap;
      int   guard;

      //        op     cnt   data     sin   exp_q    lat
      vecs[0]  = '{2'b00, 3'd0, 4'b1010, 1'b0, 4'b1010, 2};
      vecs[1]  = '{2'b01, 3'd2, 4'b0000, 1'b1, 4'b1110, 3};
      vecs[2]  = '{2'b00, 3'd0, 4'b1010, 1'b0, 4'b1010, 2};
      vecs[3]  = '{2'b10, 3'd1, 4'b1111, 1'b0, 4'b0100, 2};
      vecs[4]  = '{2'b11, 3'd3, 4'b0000, 1'b0, 4'b1000, 4};
      vecs[5]  = '{2'b11, 3'd4, 4'b0000, 1'b1, 4'b1000, 5};
      vecs[6]  = '{2'b01, 3'd0, 4'b0000, 1'b1, 4'b1000, 1};
      vecs[7]  = '{2'b10, 3'd7, 4'b0000, 1'b1, 4'b1111, 8};
      vecs[8]  = '{2'b01, 3'd5, 4'b1111, 1'b0, 4'b0000, 6};
      vecs[9]  = '{2'b00, 3'd3, 4'b0110, 1'b1, 4'b0110, 2};
      vecs[10] = '{2'b11, 3'd7, 4'b0000, 1'b0, 4'b1100, 8};
      vecs[11] = '{2'b10, 3'd2, 4'b0000, 1'b1, 4'b0011, 3};
      vecs[12] = '{2'b01, 3'd3, 4'b0000, 1'b1, 4'b1110, 4};

      // Reset state
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst sr_mode", 32'(sr_mode), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst sr_sin", 32'(sr_sin), 32'd0);
      check("rst sr_d", 32'(sr_d), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("rst cmd_ready", 32'(cmd_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         run_cmd(vecs[i], $sformatf("vec%0d", i));
      end

      // Abort a shift by reset part way through.
      v = '{2'b00, 3'd0, 4'b1010, 1'b0, 4'b1010, 2};
      run_cmd(v, "abort_preload");
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_count = 3'd5;
      cmd_sin   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      p = done_pulses;
      rst = 1'b0;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort sr_mode", 32'(sr_mode), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort partial q", 32'(sr_q), 32'b0010);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("abort no done pulse", 32'(done_pulses), 32'(p));
      check("abort q held", 32'(sr_q), 32'b0010);
      v = '{2'b00, 3'd0, 4'b0011, 1'b0, 4'b0011, 2};
      run_cmd(v, "abort_reload");

      // cmd_valid held high across back-to-back LOAD commands.
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_data  = 4'b1100;
      accepts   = 0;
      second_at = -1;
      overlap   = 0;
      for (int i = 0; i < 7; i++) begin
         if (cmd_ready === 1'b1) begin
            accepts++;
            if (accepts == 2) second_at = i;
         end
         if (done === 1'b1 && cmd_ready === 1'b1) overlap++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("b2b accepts", 32'(accepts), 32'd3);
      check("b2b second accept slot", 32'(second_at), 32'd3);
      check("b2b ready during done", 32'(overlap), 32'd0);
      check("b2b q", 32'(sr_q), 32'b1100);
      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("b2b drain idle", 32'(cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
